mop_instr_loader: RTL

//  Downstream consumer of the MoP programming controller: one instance per peripheral, driven by that peripheral's load_ctrl bit.

---
 rtl/mop_instr_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mop_instr_loader.sv
// MoP instruction loader: captures a DEPTH-word burst into a shadow bank,
// commits it atomically to an active bank, then streams the committed words
// out over a valid/ready handshake. Partial bursts never reach the active bank.
module mop_instr_loader #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  input  logic [1:0]               change_i,
  input  logic                     override_i,
  output logic                     busy_o,
  output logic                     commit_o,
  output logic                     active_vld_o,
  output logic [1:0]               mode_o,
  output logic                     err_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic [$clog2(DEPTH)-1:0] out_idx_o,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [IW:0]   W_LAST = (IW+1)'(DEPTH-1);
  localparam logic [IW:0]   W_ONE  = (IW+1)'(1);
  localparam logic [IW-1:0] R_LAST = IW'(DEPTH-1);
  localparam logic [IW-1:0] R_ONE  = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_COMMIT,
    S_STREAM
  } state_t;

  state_t                  state_q, state_d;
  logic [IW:0]             wcnt_q;
  logic [IW-1:0]           ridx_q;
  logic [DATA_WIDTH-1:0]   shadow [DEPTH];
  logic [DATA_WIDTH-1:0]   active [DEPTH];
  logic                    xfer;

  assign xfer = out_valid_o && out_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and per-state outputs
  always_comb begin
    state_d     = state_q;
    busy_o      = (state_q != S_IDLE);
    commit_o    = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_i) state_d = S_FILL;
      end
      S_FILL: begin
        // A word captured in the same cycle as override_i drops wins; abort is
        // only taken on a cycle with no word.
        if (load_i) begin
          if (wcnt_q == W_LAST) state_d = S_COMMIT;
        end else if (!override_i) begin
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        commit_o = 1'b1;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        out_valid_o = 1'b1;
        if (out_ready_i && (ridx_q == R_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow capture, counters and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
      ridx_q <= '0;
      err_o  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_i) begin
            shadow[0] <= instr_i;
            wcnt_q    <= W_ONE;
            err_o     <= 1'b0;
          end
        end
        S_FILL: begin
          if (load_i) begin
            shadow[wcnt_q[IW-1:0]] <= instr_i;
            wcnt_q                 <= wcnt_q + W_ONE;
          end else if (!override_i) begin
            wcnt_q <= '0;
            err_o  <= 1'b1;
          end
        end
        S_COMMIT: begin
          wcnt_q <= '0;
          ridx_q <= '0;
          if (load_i) err_o <= 1'b1;
        end
        S_STREAM: begin
          if (xfer) ridx_q <= ridx_q + R_ONE;
          if (load_i) err_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Active bank, mode and valid flag: updated only on commit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_o       <= '0;
      active_vld_o <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) active[i] <= '0;
    end else if (state_q == S_COMMIT) begin
      mode_o       <= change_i;
      active_vld_o <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) active[i] <= shadow[i];
    end
  end

  assign out_idx_o  = ridx_q;
  assign out_data_o = active[ridx_q];
  assign rd_data_o  = active[rd_idx_i];

endmodule
